// File: rtl/activation_scheduler.sv
// activation_scheduler
//   Round-robin arbiter that shares one activation datapath (table lookup /
//   interpolation) between N_REQ requesters. Only one operation is in flight
//   at a time. A granted z value is registered onto act_z. The datapath
//   result on act_a is captured LAT edges later. That result is then held on
//   res_a/res_tag until the consumer accepts it.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [N_REQ]     per-requester request strobe
//   req_z      in   [32*N_REQ]  per-requester signed z; requester i at [32i+31:32i]
//   req_ready  out  [N_REQ]     one-hot grant; only nonzero in IDLE
//   act_z      out  [32]        registered z driven to the shared datapath
//   act_a      in   [32]        datapath result, valid LAT cycles after act_z
//   res_valid  out  1           result available (DONE state)
//   res_a      out  [32]        captured result, bit-exact copy of act_a
//   res_tag    out  [2]         index of the requester owning res_a
//   res_ready  in   1           consumer accepts result
//   busy       out  1           high in every state except IDLE
module activation_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_z,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          act_z,
    input  logic [31:0]          act_a,
    output logic                 res_valid,
    output logic [31:0]          res_a,
    output logic [1:0]           res_tag,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] act_z_q, act_z_d;
    logic [31:0] res_a_q, res_a_d;
    logic [1:0]  res_tag_q, res_tag_d;

    logic        grant_any;
    logic [1:0]  grant_idx;
    logic [1:0]  scan_idx;
    logic        accept;

    // Scan from the farthest offset down to offset 0 so the requester closest
    // to rr_ptr (searching upward with wrap) is the last one written and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Grant is suppressed during reset so nothing can be consumed on a reset edge.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && !rst && grant_any) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        act_z_d   = act_z_q;
        res_a_d   = res_a_q;
        res_tag_d = res_tag_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    act_z_d   = req_z[32*grant_idx +: 32];
                    res_tag_d = grant_idx;
                    cnt_d     = 4'(LAT);
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                // Counter reaching 1 marks edge T+LAT: datapath output is settled.
                if (cnt_q == 4'd1) begin
                    res_a_d = act_a;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    rr_ptr_d = res_tag_q + 2'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 2'd0;
            cnt_q     <= 4'd0;
            act_z_q   <= 32'd0;
            res_a_q   <= 32'd0;
            res_tag_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            act_z_q   <= act_z_d;
            res_a_q   <= res_a_d;
            res_tag_q <= res_tag_d;
        end
    end

    assign act_z     = act_z_q;
    assign res_a     = res_a_q;
    assign res_tag   = res_tag_q;
    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_activation_scheduler.sv
// Self-checking bench for activation_scheduler. A transaction-level reference
// model (phase, pointer, remaining latency) predicts every output each cycle.
// The shared datapath is emulated as a LAT-1 deep register stage computing
// z >>> 4, or a fixed override value.
module tb_activation_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LAT   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_z;
    logic [3:0]   req_ready;
    logic [31:0]  act_z;
    logic [31:0]  act_a;
    logic         res_valid;
    logic [31:0]  res_a;
    logic [1:0]   res_tag;
    logic         res_ready;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    // Datapath emulation
    logic        dp_fixed_en = 1'b0;
    logic [31:0] dp_fixed    = 32'd0;
    logic [31:0] act_a_q     = 32'd0;

    // Reference model state
    int          m_phase;  // 0 idle, 1 waiting on datapath, 2 result held
    int          m_ptr;
    int          m_left;
    logic [31:0] m_z;
    logic [31:0] m_a;
    int          m_tag;

    activation_scheduler #(
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_z     (req_z),
        .req_ready (req_ready),
        .act_z     (act_z),
        .act_a     (act_a),
        .res_valid (res_valid),
        .res_a     (res_a),
        .res_tag   (res_tag),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        act_a_q <= dp_fixed_en ? dp_fixed : 32'($signed(act_z) >>> 4);
    end
    assign act_a = act_a_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_grant(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
        end
        return 4'd0;
    endfunction

    function automatic logic [31:0] dp_result(input logic [31:0] z);
        return dp_fixed_en ? dp_fixed : 32'($signed(z) >>> 4);
    endfunction

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic [3:0] v, input logic [127:0] z, input logic rr,
                        input logic r);
        logic [3:0] g;
        int         gi;
        @(negedge clk);
        req_valid = v;
        req_z     = z;
        res_ready = rr;
        rst       = r;
        #1;
        g = (r || m_phase != 0) ? 4'd0 : exp_grant(m_ptr, v);
        check("req_ready", 32'(req_ready), 32'(g));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("res_valid", 32'(res_valid), 32'(m_phase == 2));
        check("act_z", act_z, m_z);
        check("res_a", res_a, m_a);
        check("res_tag", 32'(res_tag), 32'(m_tag));
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_ptr = 0; m_left = 0; m_z = 0; m_a = 0; m_tag = 0;
        end else if (m_phase == 0) begin
            if (g != 4'd0) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (g[i]) gi = i;
                m_z     = z[32*gi +: 32];
                m_tag   = gi;
                m_left  = LAT;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_a     = dp_result(m_z);
                m_phase = 2;
            end
        end else if (rr) begin
            m_ptr   = (m_tag + 1) % 4;
            m_phase = 0;
        end
    endtask

    initial begin
        logic [127:0] z;
        logic [3:0]   v;
        logic         rr;
        logic         r;

        req_valid = '0; req_z = '0; res_ready = 1'b0; rst = 1'b1;
        m_phase = 0; m_ptr = 0; m_left = 0; m_z = 0; m_a = 0; m_tag = 0;

        // Reset with requests pending: no grant while rst is high
        repeat (3) step(4'b1111, '1, 1'b1, 1'b1);

        // Single request, z >>> 4 datapath
        z = '0;
        z[31:0] = 32'h015FFB80;
        repeat (5) step(4'b0001, z, 1'b1, 1'b0);
        check("single_res_a", res_a, 32'h0015FFB8);

        // Round-robin fairness with all requesters active
        z = {32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000};
        repeat (22) step(4'b1111, z, 1'b1, 1'b0);

        // Back-pressure: result must be held while consumer stalls
        repeat (4) step(4'b0001, z, 1'b0, 1'b0);
        repeat (10) step(4'b1111, z, 1'b0, 1'b0);
        repeat (3) step(4'b0000, z, 1'b1, 1'b0);

        // Serve requester 2 alone, then wrap from pointer 3 to 0 then 1
        repeat (4) step(4'b0100, z, 1'b1, 1'b0);
        repeat (10) step(4'b0011, z, 1'b1, 1'b0);

        // Reset one cycle after acceptance; in-flight result discarded
        repeat (2) step(4'b0010, z, 1'b1, 1'b0);
        step(4'b1111, z, 1'b1, 1'b1);
        repeat (6) step(4'b1111, z, 1'b1, 1'b0);
        repeat (3) step(4'b0000, z, 1'b1, 1'b0);

        // Negative z, datapath forced to a value that must pass through untouched
        dp_fixed_en = 1'b1;
        dp_fixed    = 32'h80000001;
        z = '0;
        z[95:64] = 32'hFFFF0000;
        repeat (4) step(4'b0100, z, 1'b1, 1'b0);
        check("neg_res_a", res_a, 32'h80000001);
        check("neg_res_tag", 32'(res_tag), 32'd2);
        repeat (2) step(4'b0000, z, 1'b1, 1'b0);
        dp_fixed_en = 1'b0;

        // Randomized traffic with random back-pressure and occasional reset
        for (int n = 0; n < 600; n++) begin
            z  = {$urandom, $urandom, $urandom, $urandom};
            v  = 4'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 60) == 0);
            step(v, z, rr, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/activation_scheduler.md
ACTIVATION_SCHEDULER -- requirements
Module: activation_scheduler

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one activation (table-lookup/interpolation) datapath; fixed at 4 for this release.
REQ-002 Parameter: LAT, 2, cycles the shared datapath needs from a stable act_z to a valid act_a; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: req_valid  input  4  per-requester request strobe; bit i belongs to requester i.
REQ-006 Port: req_z  input  128  per-requester signed 32-bit pre-activation value; requester i occupies bits [32i+31:32i].
REQ-007 Port: req_ready  output  4  one-hot accept; request i is consumed on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-008 Port: act_z  output  32  registered signed z value driven to the shared datapath.
REQ-009 Port: act_a  input  32  signed activation result returned by the shared datapath.
REQ-010 Port: res_valid  output  1  result available.
REQ-011 Port: res_a  output  32  registered signed activation result.
REQ-012 Port: res_tag  output  2  index of the requester that owns res_a.
REQ-013 Port: res_ready  input  1  consumer accepts the result on an edge where res_valid and res_ready are both 1.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, BUSY, DONE.
REQ-016 In IDLE, req_ready SHALL be combinationally one-hot on the first asserted req_valid bit searched upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod 4); all zero if no req_valid is set or state is not IDLE.
REQ-017 On an accepting edge T, the block SHALL register act_z from the granted slice of req_z, register res_tag with the grant index, load a 4-bit counter with LAT, and enter BUSY.
REQ-018 act_z SHALL hold its value unchanged from edge T until the next accepting edge.
REQ-019 In BUSY the counter SHALL decrement each edge; on the edge where the counter equals 1 (edge T+LAT) the block SHALL capture act_a into res_a and enter DONE.
REQ-020 res_valid SHALL be 1 exactly while in DONE; res_a and res_tag SHALL be stable while res_valid is 1.
REQ-021 In DONE, on an edge with res_ready=1, the block SHALL enter IDLE and set rr_ptr to (res_tag+1) mod 4; with res_ready=0 it SHALL remain in DONE indefinitely.
REQ-022 No new request SHALL be accepted in BUSY or DONE; minimum issue interval is LAT+2 cycles (accept, LAT busy edges, 1 handshake edge).
REQ-023 A requester dropping req_valid before acceptance SHALL lose no state; it is simply not granted.
REQ-024 res_a SHALL be a bit-exact copy of act_a; no saturation, rounding or sign change is applied.

Reset
REQ-025 On rst=1 at an edge, regardless of state: state=IDLE, rr_ptr=0, counter=0, act_z=0, res_a=0, res_tag=0, res_valid=0, busy=0; an in-flight operation SHALL be discarded and never reported.
REQ-026 While rst=1, req_ready SHALL be all zero.

Verification
REQ-027 Single request: LAT=2, req_valid=4'b0001, req_z[31:0]=32'h015FFB80, act_a model = z>>>4 -> req_ready=4'b0001 at T, act_z=32'h015FFB80 from T, res_valid=1 from T+2 with res_a=32'h0015FFB8, res_tag=0.
REQ-028 Round-robin fairness: all four req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0, one every 4 cycles (LAT=2).
REQ-029 Back-pressure: res_ready=0 for 10 cycles after res_valid rises -> res_valid, res_a, res_tag stable, busy=1, req_ready=0 throughout; release res_ready -> IDLE next edge.
REQ-030 Wrap/skip: rr_ptr=3 (after serving requester 2), req_valid=4'b0011 -> requester 0 granted, then requester 1.
REQ-031 Reset mid-operation: assert rst one cycle after acceptance -> res_valid never asserts, all outputs zero next edge, rr_ptr=0 so requester 0 granted first afterwards.
REQ-032 Negative value: req_z slice 2 = 32'hFFFF0000, act_a driven 32'h80000001 -> res_a=32'h80000001, res_tag=2 (no modification).
